// File: rtl/vpu_pkg.sv
// Shared types for the VPU lane controller: opcodes, FSM states, limits and
// the opcode decoder that yields a legal flag plus required-operand mask.
package vpu_pkg;

    localparam int unsigned OPERAND_WIDTH          = 16;
    localparam int unsigned SRC_OPERAND_CNT        = 3;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [3:0] {
        OP_FADD   = 4'd0,
        OP_FSUB   = 4'd1,
        OP_FMUL   = 4'd2,
        OP_FDIV   = 4'd3,
        OP_FMAX2  = 4'd4,
        OP_FAVG2  = 4'd5,
        OP_FADD3  = 4'd6,
        OP_FMAX3  = 4'd7,
        OP_FAVG3  = 4'd8,
        OP_FSQRT  = 4'd9,
        OP_FEXP   = 4'd10,
        OP_FRECIP = 4'd11
    } vpu_h2d_req_opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } vpu_lane_state_t;

    typedef struct packed {
        logic                       legal;
        logic [SRC_OPERAND_CNT-1:0] req_mask;
    } vpu_op_info_t;

    // Encodings 12..15 are unassigned and decode as illegal.
    function automatic vpu_op_info_t vpu_op_decode(input vpu_h2d_req_opcode_t op);
        vpu_op_info_t info;
        info.legal    = 1'b1;
        info.req_mask = '0;
        case (op)
            OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FMAX2, OP_FAVG2:
                info.req_mask = SRC_OPERAND_CNT'(3'b011);
            OP_FADD3, OP_FMAX3, OP_FAVG3:
                info.req_mask = SRC_OPERAND_CNT'(3'b111);
            OP_FSQRT, OP_FEXP, OP_FRECIP:
                info.req_mask = SRC_OPERAND_CNT'(3'b001);
            default:
                info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/vpu_lane_timeout_cnt.sv
// WAIT-state watchdog: counts stalled cycles and flags when LIMIT-1 is reached.
module vpu_lane_timeout_cnt #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !expired_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/vpu_lane_ctrl.sv
// Single-request host-to-lane sequencer (IDLE/ISSUE/WAIT/RESP).
// Define VPU_LANE_CTRL_TIMEOUT_EN to bound the WAIT state with a watchdog.
module vpu_lane_ctrl
    import vpu_pkg::*;
#(
    parameter int unsigned SRC_CNT        = SRC_OPERAND_CNT,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  vpu_h2d_req_opcode_t              req_opcode_i,
    input  logic [SRC_CNT*OPERAND_WIDTH-1:0] req_operand_i,
    input  logic [SRC_CNT-1:0]               req_operand_valid_i,
    output logic                             lane_start_o,
    output vpu_h2d_req_opcode_t              lane_opcode_o,
    output logic [SRC_CNT*OPERAND_WIDTH-1:0] lane_operand_o,
    output logic [SRC_CNT-1:0]               lane_operand_valid_o,
    input  logic [OPERAND_WIDTH-1:0]         lane_dout_i,
    input  logic                             lane_done_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]         rsp_data_o,
    output logic                             rsp_err_o,
    output logic                             busy_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("vpu_lane_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    vpu_lane_state_t    state_q, state_d;
    vpu_op_info_t       op_info;
    logic [SRC_CNT-1:0] req_mask;
    logic               req_ok;
    logic               ld_req, ld_ok, ld_err;
    logic               timeout_c;

    assign op_info  = vpu_op_decode(req_opcode_i);
    assign req_mask = SRC_CNT'(op_info.req_mask);
    assign req_ok   = op_info.legal && ((req_mask & ~req_operand_valid_i) == '0);

`ifdef VPU_LANE_CTRL_TIMEOUT_EN
    // Cleared during ISSUE so the count starts at zero on the first WAIT cycle.
    vpu_lane_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q == ST_ISSUE),
        .inc      ((state_q == ST_WAIT) && !lane_done_i),
        .expired_c(timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next state and load strobes; done takes priority over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        ld_req  = 1'b0;
        ld_ok   = 1'b0;
        ld_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    ld_req = 1'b1;
                    if (req_ok) begin
                        state_d = ST_ISSUE;
                    end else begin
                        ld_err  = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (lane_done_i) begin
                    ld_ok   = 1'b1;
                    state_d = ST_RESP;
                end else if (timeout_c) begin
                    ld_err  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs are flopped from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q              <= ST_IDLE;
            req_ready_o          <= 1'b1;
            lane_start_o         <= 1'b0;
            rsp_valid_o          <= 1'b0;
            busy_o               <= 1'b0;
            rsp_err_o            <= 1'b0;
            rsp_data_o           <= '0;
            lane_opcode_o        <= OP_FADD;  // encoding zero
            lane_operand_o       <= '0;
            lane_operand_valid_o <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_o  <= (state_d == ST_IDLE);
            lane_start_o <= (state_d == ST_ISSUE);
            rsp_valid_o  <= (state_d == ST_RESP);
            busy_o       <= (state_d != ST_IDLE);
            if (ld_req) begin
                lane_opcode_o        <= req_opcode_i;
                lane_operand_o       <= req_operand_i;
                lane_operand_valid_o <= req_operand_valid_i;
            end
            if (ld_ok) begin
                rsp_data_o <= lane_dout_i;
                rsp_err_o  <= 1'b0;
            end else if (ld_err) begin
                rsp_data_o <= '0;
                rsp_err_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vpu_lane_ctrl.sv
// Scoreboard bench for vpu_lane_ctrl with a behavioural lane of programmable latency.
// Timeout scenarios run when VPU_LANE_CTRL_TIMEOUT_EN is defined.
module tb_vpu_lane_ctrl;
    import vpu_pkg::*;

    localparam int unsigned W = OPERAND_WIDTH;
    localparam int unsigned N = SRC_OPERAND_CNT;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid_i;
    logic                req_ready_o;
    vpu_h2d_req_opcode_t req_opcode_i;
    logic [N*W-1:0]      req_operand_i;
    logic [N-1:0]        req_operand_valid_i;
    logic                lane_start_o;
    vpu_h2d_req_opcode_t lane_opcode_o;
    logic [N*W-1:0]      lane_operand_o;
    logic [N-1:0]        lane_operand_valid_o;
    logic [W-1:0]        lane_dout_i;
    logic                lane_done_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [W-1:0]        rsp_data_o;
    logic                rsp_err_o;
    logic                busy_o;

    logic         model_done, inj_done;
    logic [W-1:0] model_dout, inj_dout;
    assign lane_done_i = model_done | inj_done;
    assign lane_dout_i = inj_done ? inj_dout : model_dout;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           start_cnt = 0;
    int           lane_lat = -1;
    logic [W-1:0] lane_result = '0;
    logic [W:0]   sb_q[$];
    logic [W:0]   sb_exp;

    always #5 clk = ~clk;

    vpu_lane_ctrl #(
        .SRC_CNT       (N),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_opcode_i        (req_opcode_i),
        .req_operand_i       (req_operand_i),
        .req_operand_valid_i (req_operand_valid_i),
        .lane_start_o        (lane_start_o),
        .lane_opcode_o       (lane_opcode_o),
        .lane_operand_o      (lane_operand_o),
        .lane_operand_valid_o(lane_operand_valid_o),
        .lane_dout_i         (lane_dout_i),
        .lane_done_i         (lane_done_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_data_o          (rsp_data_o),
        .rsp_err_o           (rsp_err_o),
        .busy_o              (busy_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Lane model: done pulse lane_lat cycles after the start pulse (never if negative).
    initial begin : lane_model
        int cnt;
        cnt        = -1;
        model_done = 1'b0;
        model_dout = '0;
        forever begin
            @(posedge clk); #1;
            model_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_done = 1'b1;
                    model_dout = lane_result;
                    cnt        = -1;
                end
            end
            if (lane_start_o) begin
                start_cnt++;
                cnt = lane_lat;
            end
        end
    end

    // Response monitor: pop the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check_eq("rsp_data", 64'(rsp_data_o), 64'(sb_exp[W-1:0]));
                check_eq("rsp_err", 64'(rsp_err_o), 64'(sb_exp[W]));
            end
        end
    end

    task automatic send(input vpu_h2d_req_opcode_t op, input logic [N*W-1:0] ops,
                        input logic [N-1:0] vld, input int lat, input logic [W-1:0] res,
                        input logic exp_err, input int exp_lat, input int exp_starts,
                        input int hold, input bit b2b);
        int           n;
        int           s0;
        logic [W-1:0] exp_data;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_ready", 64'(req_ready_o), 64'd1);
        exp_data            = exp_err ? '0 : res;
        lane_lat            = lat;
        lane_result         = res;
        req_valid_i         = 1'b1;
        req_opcode_i        = op;
        req_operand_i       = ops;
        req_operand_valid_i = vld;
        sb_q.push_back({exp_err, exp_data});
        s0 = start_cnt;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", 64'(n + 1), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            inj_done = i[0];
            inj_dout = ~exp_data;
            @(posedge clk); #1;
            inj_done = 1'b0;
            check_eq("hold_data", 64'(rsp_data_o), 64'(exp_data));
            check_eq("hold_ready", 64'(req_ready_o), 64'd0);
            check_eq("hold_valid", 64'(rsp_valid_o), 64'd1);
        end
        check_eq("lane_opcode", 64'(lane_opcode_o), 64'(op));
        check_eq("lane_operand", 64'(lane_operand_o), 64'(ops));
        check_eq("lane_valid", 64'(lane_operand_valid_o), 64'(vld));
        rsp_ready_i = 1'b1;
        if (b2b) req_valid_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        check_eq("start_pulses", 64'(start_cnt - s0), 64'(exp_starts));
        if (b2b) begin
            check_eq("b2b_not_taken", 64'(busy_o), 64'd0);
            check_eq("b2b_ready", 64'(req_ready_o), 64'd1);
        end
    endtask

    initial begin : main
        bit seen;
        rst_n               = 1'b0;
        req_valid_i         = 1'b0;
        req_opcode_i        = OP_FADD;
        req_operand_i       = '0;
        req_operand_valid_i = '0;
        rsp_ready_i         = 1'b0;
        inj_done            = 1'b0;
        inj_dout            = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_ready", 64'(req_ready_o), 64'd1);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("rst_start", 64'(lane_start_o), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data_o), 64'd0);
        check_eq("rst_rsp_err", 64'(rsp_err_o), 64'd0);

        send(OP_FMUL,   {16'h0000, 16'h4000, 16'h3F80}, 3'b011, 3, 16'h4000, 1'b0, 5, 1, 0, 1'b0);
        send(OP_FADD3,  {16'h0000, 16'h1111, 16'h2222}, 3'b011, 3, 16'h7777, 1'b1, 1, 0, 0, 1'b0);
        send(OP_FSQRT,  {16'hAAAA, 16'hBBBB, 16'h4400}, 3'b001, 1, 16'h3C00, 1'b0, 3, 1, 0, 1'b1);
        send(OP_FADD3,  {16'h3C00, 16'h4000, 16'h4200}, 3'b111, 6, 16'h4500, 1'b0, 8, 1, 0, 1'b0);
        send(vpu_h2d_req_opcode_t'(4'd13), {16'h1, 16'h2, 16'h3}, 3'b111, 2, 16'h9999, 1'b1, 1, 0, 0, 1'b0);
        send(OP_FDIV,   {16'h4000, 16'h0000, 16'h3F80}, 3'b101, 2, 16'h5555, 1'b1, 1, 0, 0, 1'b0);
        send(OP_FAVG2,  {16'h0000, 16'h1000, 16'h3000}, 3'b011, 2, 16'h2000, 1'b0, 4, 1, 10, 1'b0);
        send(OP_FEXP,   {16'h0000, 16'h1000, 16'h3000}, 3'b110, 2, 16'h2000, 1'b1, 1, 0, 0, 1'b0);
        send(OP_FRECIP, {16'h0000, 16'h0000, 16'h4000}, 3'b001, 4, 16'h3800, 1'b0, 6, 1, 0, 1'b0);

        // Reset while in WAIT; the lane's late done must be ignored.
        lane_lat            = 6;
        lane_result         = 16'h1234;
        req_valid_i         = 1'b1;
        req_opcode_i        = OP_FADD;
        req_operand_i       = {16'h0, 16'h4000, 16'h4000};
        req_operand_valid_i = 3'b011;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid_o || busy_o || lane_start_o) seen = 1'b1;
        end
        check_eq("post_rst_quiet", 64'(seen), 64'd0);
        check_eq("post_rst_ready", 64'(req_ready_o), 64'd1);
        check_eq("post_rst_data", 64'(rsp_data_o), 64'd0);
        check_eq("post_rst_err", 64'(rsp_err_o), 64'd0);
        check_eq("post_rst_opcode", 64'(lane_opcode_o), 64'd0);
        check_eq("post_rst_operand", 64'(lane_operand_o), 64'd0);
        check_eq("post_rst_valid", 64'(lane_operand_valid_o), 64'd0);

        send(OP_FMAX3, {16'h0003, 16'h0002, 16'h0001}, 3'b111, 2, 16'h0003, 1'b0, 4, 1, 0, 1'b0);
`ifdef VPU_LANE_CTRL_TIMEOUT_EN
        send(OP_FSUB, {16'h0, 16'h1, 16'h2}, 3'b011, -1, 16'hDEAD, 1'b1, 10, 1, 0, 1'b0);
        send(OP_FSUB, {16'h0, 16'h1, 16'h2}, 3'b011, 8, 16'h55AA, 1'b0, 10, 1, 0, 1'b0);
`endif
        repeat (2) @(posedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
